// File: rtl/chunk_assembler.sv
// Gathers a raster pixel stream into CELL_SIZE x ROW_PIX chunks for chunk_transposer.
// Define CHUNK_ASM_DOUBLE_BUF_EN for ping-pong fill banks; otherwise a single bank is used.
//
// Per-bank state | meaning
// ---------------+------------------------------------------------
// EMPTY          | no pixels held, available for filling
// FILLING        | receiving pixels of the current chunk
// FULL           | complete chunk waiting for downstream acceptance
module chunk_assembler #(
  parameter  int CELL_SIZE  = 2,
  parameter  int CHUNK_SIZE = 64,
  localparam int ROW_PIX    = CELL_SIZE * CHUNK_SIZE,
  localparam int NPIX       = ROW_PIX * CELL_SIZE,
  localparam int CW         = 24 * NPIX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   s_pixel,
  input  logic          s_valid,
  input  logic          s_eol,
  output logic          s_ready,
  output logic [CW-1:0] m_chunk,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          err_eol
);

`ifdef CHUNK_ASM_DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int COLW = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam int ROWW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_t;

  bank_st_t        r_st     [NBANK];
  bank_st_t        w_st_nxt [NBANK];
  logic [CW-1:0]   r_bank   [NBANK];
  logic            r_wr_sel;
  logic            r_rd_sel;
  logic [COLW-1:0] r_col;
  logic [ROWW-1:0] r_row;
  logic            r_err_eol;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_col_last;
  logic            w_last;
  logic [IDXW-1:0] w_idx;

  assign w_in_xfer  = s_valid & s_ready;
  assign w_out_xfer = m_valid & m_ready;
  assign w_col_last = (r_col == COLW'(ROW_PIX - 1));
  assign w_last     = w_col_last && (r_row == ROWW'(CELL_SIZE - 1));
  assign w_idx      = IDXW'(r_row) * IDXW'(ROW_PIX) + IDXW'(r_col);

  // Bank state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) r_st[b] <= EMPTY;
    end else begin
      for (int b = 0; b < NBANK; b++) r_st[b] <= w_st_nxt[b];
    end
  end

  // A bank can never take a pixel and be emitted in the same cycle: input needs
  // it non-FULL, output needs it FULL. The two transfers always hit different banks.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      w_st_nxt[b] = r_st[b];
      case (r_st[b])
        EMPTY:   if (w_in_xfer && r_wr_sel == 1'(b)) w_st_nxt[b] = w_last ? FULL : FILLING;
        FILLING: if (w_in_xfer && r_wr_sel == 1'(b) && w_last) w_st_nxt[b] = FULL;
        FULL:    if (w_out_xfer && r_rd_sel == 1'(b)) w_st_nxt[b] = EMPTY;
        default: w_st_nxt[b] = EMPTY;
      endcase
    end
  end

  always_comb begin
    s_ready = (r_st[r_wr_sel] != FULL);
    m_valid = (r_st[r_rd_sel] == FULL);
  end

  assign m_chunk = r_bank[r_rd_sel];
  assign err_eol = r_err_eol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_err_eol <= 1'b0;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      for (int b = 0; b < NBANK; b++) r_bank[b] <= '0;
    end else begin
      if (w_in_xfer) begin
        r_bank[r_wr_sel][24*w_idx +: 24] <= s_pixel;
        // Row-length errors are only flagged; position tracking is left untouched.
        if (s_eol != w_col_last) r_err_eol <= 1'b1;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_last ? '0 : ROWW'(r_row + 1'b1);
        end else begin
          r_col <= COLW'(r_col + 1'b1);
        end
        if (w_last && NBANK == 2) r_wr_sel <= ~r_wr_sel;
      end
      if (w_out_xfer && NBANK == 2) r_rd_sel <= ~r_rd_sel;
    end
  end

endmodule

// File: tb/tb_chunk_assembler.sv
// Directed bench for chunk_assembler; double-buffer scenarios run when
// CHUNK_ASM_DOUBLE_BUF_EN is defined, single-bank scenarios otherwise.
module tb_chunk_assembler;
  localparam int CW = 6144;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   s_pixel;
  logic          s_valid;
  logic          s_eol;
  logic          s_ready;
  logic [CW-1:0] m_chunk;
  logic          m_valid;
  logic          m_ready;
  logic          err_eol;

  int n_checks = 0;
  int n_err    = 0;

  chunk_assembler dut (
    .clk     (clk),
    .rst     (rst),
    .s_pixel (s_pixel),
    .s_valid (s_valid),
    .s_eol   (s_eol),
    .s_ready (s_ready),
    .m_chunk (m_chunk),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .err_eol (err_eol)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] field(input int i);
    return m_chunk[24*i +: 24];
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents one pixel and returns 1 ns after the edge that accepted it; s_valid stays high.
  task automatic send_px(input logic [23:0] p, input logic eol);
    int n;
    s_pixel = p; s_eol = eol; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) check_eq("px_wait_s_ready", s_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;
    int bad;
    logic acc;

    rst = 1'b1; s_valid = 1'b0; s_pixel = '0; s_eol = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_err_eol", err_eol, 0);
    check_eq("rst_chunk_zero", |m_chunk, 0);
    rst = 1'b0;

    // Basic fill with m_ready high
    m_ready = 1'b1;
    for (int i = 0; i < 256; i++) send_px(24'(i), (i == 127) || (i == 255));
    s_valid = 1'b0;
    check_eq("t1_m_valid", m_valid, 1);
    check_eq("t1_px0", field(0), 24'd0);
    check_eq("t1_px128", field(128), 24'd128);
    check_eq("t1_px255", field(255), 24'd255);
    check_eq("t1_err_eol", err_eol, 0);
    @(posedge clk); #1;
    check_eq("t1_consumed", m_valid, 0);
    m_ready = 1'b0;

`ifndef CHUNK_ASM_DOUBLE_BUF_EN
    // Single bank: stall after one chunk, resume after output transfer
    do_reset();
    cnt = 0;
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      s_pixel = 24'(cnt); s_eol = (cnt % 128 == 127);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) cnt++;
    end
    check_eq("t2_accepts", cnt, 256);
    check_eq("t2_s_ready_stall", s_ready, 0);
    check_eq("t2_m_valid", m_valid, 1);
    check_eq("t2_px200", field(200), 24'd200);
    m_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t2_m_valid_after", m_valid, 0);
    check_eq("t2_s_ready_resume", s_ready, 1);
    m_ready = 1'b0; s_valid = 1'b0;
`else
    // Double bank: two chunks buffered, emitted in arrival order
    do_reset();
    cnt = 0;
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!s_ready) break;
      s_pixel = 24'(cnt); s_eol = (cnt % 128 == 127);
      @(posedge clk); #1;
      cnt++;
    end
    s_valid = 1'b0;
    check_eq("t3_accepts", cnt, 512);
    check_eq("t3_s_ready_stall", s_ready, 0);
    check_eq("t3_c0_px0", field(0), 24'd0);
    check_eq("t3_c0_px255", field(255), 24'd255);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check_eq("t3_c1_valid", m_valid, 1);
    check_eq("t3_c1_px0", field(0), 24'd256);
    check_eq("t3_c1_px255", field(255), 24'd511);
    check_eq("t3_s_ready_free", s_ready, 1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check_eq("t3_drained", m_valid, 0);
`endif

    // Row-length error is sticky and does not disturb placement
    do_reset();
    check_eq("t4_err_cleared", err_eol, 0);
    for (int i = 0; i < 256; i++) begin
      send_px(24'h010000 + 24'(i), (i == 100) || (i == 127) || (i == 255));
      if (i == 99)  check_eq("t4_err_before", err_eol, 0);
      if (i == 100) check_eq("t4_err_set", err_eol, 1);
    end
    s_valid = 1'b0;
    check_eq("t4_err_sticky", err_eol, 1);
    check_eq("t4_m_valid", m_valid, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (field(i) !== 24'h010000 + 24'(i)) bad++;
    check_eq("t4_fields_bad", bad, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check_eq("t4_err_after_out", err_eol, 1);

    // Reset mid-fill discards the partial chunk
    do_reset();
    check_eq("t5_err_cleared", err_eol, 0);
    for (int i = 0; i < 100; i++) send_px(24'(i), 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_m_valid_rst", m_valid, 0);
    rst = 1'b0;
    check_eq("t5_s_ready_rst", s_ready, 1);
    for (int i = 0; i < 256; i++) send_px(24'hA5A5A5, (i == 127) || (i == 255));
    s_valid = 1'b0;
    check_eq("t5_m_valid", m_valid, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (field(i) !== 24'hA5A5A5) bad++;
    check_eq("t5_fields_bad", bad, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;

`ifdef CHUNK_ASM_DOUBLE_BUF_EN
    // Final pixel of chunk 1 and output of chunk 0 in the same cycle
    do_reset();
    for (int i = 0; i < 511; i++) send_px(24'(i), (i % 128 == 127));
    check_eq("t6_c0_held", m_valid, 1);
    check_eq("t6_c0_px0", field(0), 24'd0);
    m_ready = 1'b1;
    send_px(24'd511, 1'b1);
    m_ready = 1'b0;
    s_valid = 1'b0;
    check_eq("t6_c1_valid", m_valid, 1);
    check_eq("t6_c1_px0", field(0), 24'd256);
    check_eq("t6_c1_px255", field(255), 24'd511);
    check_eq("t6_no_bubble", s_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
